// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues handshaked commands to a 4-bit ALU and queues tagged results in a small FIFO.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic [7:0]       in_opcode,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [7:0]       alu_opcode,
    input  logic [7:0]       alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_err,
    output logic [7:0]       out_opcode,
    output logic [CNT_W-1:0] cmd_count,
    output logic [7:0]       err_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [16:0]     mem [DEPTH];
    logic            accept, push, pop, oor, div_zero, err;
    logic [7:0]      data;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        push     = 1'b0;
        if (state == IDLE) begin
            in_ready = count < FULL;
            state_nx = (in_valid && in_ready) ? EXEC : IDLE;
        end else begin
            push     = 1'b1;
            state_nx = IDLE;
        end
    end

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    // Division by zero overrides the ALU output; out-of-range opcodes pass it through.
    assign oor      = alu_opcode > 8'h0F;
    assign div_zero = (alu_opcode == 8'h03 || alu_opcode == 8'h04) && alu_b == 4'h0;
    assign err      = oor || div_zero;
    assign data     = div_zero ? 8'hFF : alu_result;

    assign out_valid = count != '0;
    assign {out_data, out_err, out_opcode} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cmd_count  <= '0;
            err_count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                alu_a      <= in_a;
                alu_b      <= in_b;
                alu_opcode <= in_opcode;
                cmd_count  <= cmd_count + CNT_W'(1);
            end
            if (push) begin
                mem[wr_ptr] <= {data, err, alu_opcode};
                wr_ptr      <= wr_ptr + AW'(1);
                if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed stimulus with a queue-based reference model checked every cycle.
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [3:0]       in_a, in_b, alu_a, alu_b;
    logic [7:0]       in_opcode, alu_opcode, alu_result, out_data, out_opcode, err_count;
    logic [CNT_W-1:0] cmd_count;

    int tests = 0;
    int fails = 0;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_opcode(out_opcode),
        .cmd_count(cmd_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Reference ALU seen by the DUT: add, sub, mul, div, mod, and, or, xor, concat.
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [7:0] op);
        logic [7:0] x, y;
        x = {4'h0, a};
        y = {4'h0, b};
        case (op)
            8'h00: return x + y;
            8'h01: return x - y;
            8'h02: return x * y;
            8'h03: return (y != 0) ? x / y : 8'h00;
            8'h04: return (y != 0) ? x % y : 8'h00;
            8'h05: return x & y;
            8'h06: return x | y;
            8'h07: return x ^ y;
            8'h09: return {a, b};
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_opcode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: expected FIFO contents, one in-flight command, counters.
    logic [16:0] q[$];
    logic [16:0] seen[$];
    bit          armed = 0;
    bit          infl = 0;
    logic [3:0]  ea = 0, eb = 0;
    logic [7:0]  eo = 0, e_data;
    logic [3:0]  ecmd = 0;
    int          eerr = 0;
    bit          exp_ready, e_err;

    always @(negedge clk) begin
        exp_ready = !infl && q.size() < DEPTH;
        if (armed) begin
            chk("in_ready", in_ready, exp_ready);
            chk("out_valid", out_valid, q.size() != 0);
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
            chk("alu_opcode", alu_opcode, eo);
            chk("cmd_count", cmd_count, ecmd);
            chk("err_count", err_count, eerr);
            if (q.size() != 0) chk("head", {out_data, out_err, out_opcode}, q[0]);
        end
        if (!rst_n) begin
            q.delete();
            infl = 0;
            ea = 0; eb = 0; eo = 0; ecmd = 0; eerr = 0;
            armed = 1;
        end else if (armed) begin
            if (out_valid && out_ready) seen.push_back({out_data, out_err, out_opcode});
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (infl) begin
                e_err  = eo > 8'h0F || ((eo == 8'h03 || eo == 8'h04) && eb == 0);
                e_data = ((eo == 8'h03 || eo == 8'h04) && eb == 0) ? 8'hFF : alu_fn(ea, eb, eo);
                q.push_back({e_data, e_err, eo});
                if (e_err && eerr < 255) eerr++;
            end
            infl = in_valid && exp_ready;
            if (infl) begin
                ea = in_a; eb = in_b; eo = in_opcode; ecmd = ecmd + 4'd1;
            end
        end
    end

    // Presents a command and returns 1 time unit after the accepting edge; in_valid stays high.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [7:0] op);
        bit ok = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_opcode = op;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = 0; in_b = 0; in_opcode = 0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_cmd", cmd_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_head", {out_data, out_err, out_opcode}, 0);
        chk("rst_alu_a", alu_a, 0);

        send(4'd3, 4'd5, 8'h00);
        in_valid = 1'b0;
        chk("exec_alu_a", alu_a, 3);
        chk("exec_alu_b", alu_b, 5);
        @(posedge clk); #1;
        chk("first_valid", out_valid, 1);
        chk("first_entry", {out_data, out_err, out_opcode}, {8'h08, 1'b0, 8'h00});
        chk("first_cmd", cmd_count, 1);

        send(4'd7, 4'd9, 8'h02);
        send(4'hF, 4'h2, 8'h09);
        send(4'd9, 4'd0, 8'h03);
        send(4'd1, 4'd2, 8'h10);
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("seen0", seen[0], {8'h08, 1'b0, 8'h00});
        chk("seen1", seen[1], {8'h3F, 1'b0, 8'h02});
        chk("seen2", seen[2], {8'hF2, 1'b0, 8'h09});
        chk("seen3", seen[3], {8'hFF, 1'b1, 8'h03});
        chk("seen4", seen[4], {8'h00, 1'b1, 8'h10});
        chk("err_two", err_count, 2);

        out_ready = 1'b0;
        send(4'd1, 4'd1, 8'h00);
        send(4'd2, 4'd3, 8'h00);
        send(4'd4, 4'd4, 8'h02);
        send(4'd5, 4'd1, 8'h01);
        in_a = 4'd6; in_b = 4'd2; in_opcode = 8'h07;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            chk("full_out_valid", out_valid, 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        send(4'd6, 4'd2, 8'h07);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("pushpop_head", {out_data, out_err, out_opcode}, {8'h10, 1'b0, 8'h02});
        repeat (6) @(posedge clk); #1;
        chk("seen5", seen[5], {8'h02, 1'b0, 8'h00});
        chk("seen6", seen[6], {8'h05, 1'b0, 8'h00});
        chk("seen7", seen[7], {8'h10, 1'b0, 8'h02});
        chk("seen8", seen[8], {8'h04, 1'b0, 8'h01});
        chk("seen9", seen[9], {8'h04, 1'b0, 8'h07});
        chk("drained", out_valid, 0);

        send(4'd2, 4'd2, 8'h00);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("exec_rst_valid", out_valid, 0);
        chk("exec_rst_cmd", cmd_count, 0);
        chk("exec_rst_err", err_count, 0);
        chk("exec_rst_ready", in_ready, 1);
        repeat (4) @(posedge clk); #1;
        chk("no_ghost", seen.size(), 10);

        for (int i = 0; i < 17; i++) send(4'(i), 4'd1, 8'h00);
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("cmd_wrap", cmd_count, 1);

        for (int i = 0; i < 258; i++) send(4'(i), 4'(i), 8'h20);
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("err_sat", err_count, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
